noc2_pkt_store_fwd_buf: RTL and testbench

- Credit-based NoC2 receive buffer between the chip's processor→offchip NoC2 port and the val/rdy input of the NoC→AXI4 bridge.
- Accepts flits under yummy credit flow control and stores them in a flit FIFO.
- Presents val/rdy output only once a whole packet is buffered (store-and-forward), so the bridge never stalls mid-packet waiting on the chip.
- Returns one yummy per flit drained.

---
 rtl/noc2_pkt_store_fwd_buf_if.sv | 21 ++
 rtl/noc2_pkt_store_fwd_buf.sv | 157 +++++++++++++++
 tb/tb_noc2_pkt_store_fwd_buf.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/noc2_pkt_store_fwd_buf_if.sv
// rtl/noc2_pkt_store_fwd_buf_if.sv - NoC2 flit bus: credit-side input, val/rdy-side output
interface noc2_pkt_store_fwd_buf_if #(
    parameter int NOC_DATA_WIDTH = 64
);
    logic [NOC_DATA_WIDTH-1:0] data_in;
    logic                      valid_in;
    logic                      yummy_out;
    logic [NOC_DATA_WIDTH-1:0] data_out;
    logic                      valid_out;
    logic                      ready_in;

    modport slave (
        input  data_in, valid_in, ready_in,
        output yummy_out, data_out, valid_out
    );

    modport master (
        output data_in, valid_in, ready_in,
        input  yummy_out, data_out, valid_out
    );
endinterface

// File: rtl/noc2_pkt_store_fwd_buf.sv
// rtl/noc2_pkt_store_fwd_buf.sv - credit-in, val/rdy-out NoC2 store-and-forward flit buffer
// NOC2_PKT_BUF_CUT_THROUGH_EN: offer the head flit whenever the FIFO is non-empty.
module noc2_pkt_store_fwd_buf #(
    parameter int NOC_DATA_WIDTH = 64,
    parameter int DEPTH          = 16,
    parameter int LEN_LSB        = 22,
    parameter int LEN_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    noc2_pkt_store_fwd_buf_if.slave  bus,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {W_HDR, W_BODY} wstate_e;
    typedef enum logic {R_HDR, R_BODY} rstate_e;

    logic [NOC_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [AW:0]               occ_q, occ_d;
    logic [AW:0]               pkt_cnt_q, pkt_cnt_d;
    wstate_e                   wstate_q, wstate_d;
    rstate_e                   rstate_q, rstate_d;
    logic [LEN_WIDTH-1:0]      wrem_q, wrem_d;
    logic [LEN_WIDTH-1:0]      rrem_q, rrem_d;
    logic                      yummy_q;
    logic                      overflow_q, overflow_d;

    logic [NOC_DATA_WIDTH-1:0] head;
    logic [LEN_WIDTH-1:0]      wr_len, rd_len;
    logic                      full, empty, valid_out, deq, wr_en;
    logic                      pkt_done, tail_deq;

    assign head   = mem_q[rd_ptr_q];
    assign wr_len = bus.data_in[LEN_LSB +: LEN_WIDTH];
    assign rd_len = head[LEN_LSB +: LEN_WIDTH];
    assign full   = (occ_q == FULL_CNT);
    assign empty  = (occ_q == '0);

`ifdef NOC2_PKT_BUF_CUT_THROUGH_EN
    assign valid_out = !empty;
`else
    // The full term lets packets longer than the buffer cut through instead of deadlocking.
    assign valid_out = !empty && ((pkt_cnt_q != '0) || (rstate_q == R_BODY) || full);
`endif

    assign deq   = valid_out && bus.ready_in;
    // A dequeue in the same cycle frees the slot, so a full buffer may still accept.
    assign wr_en = bus.valid_in && (!full || deq);

    assign bus.data_out  = head;
    assign bus.valid_out = valid_out;
    assign bus.yummy_out = yummy_q;
    assign occupancy_o   = occ_q;
    assign overflow_o    = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        pkt_cnt_d  = pkt_cnt_q;
        wstate_d   = wstate_q;
        rstate_d   = rstate_q;
        wrem_d     = wrem_q;
        rrem_d     = rrem_q;
        overflow_d = overflow_q;
        pkt_done   = 1'b0;
        tail_deq   = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wstate_q == W_HDR) begin
                if (wr_len == '0) begin
                    pkt_done = 1'b1;
                end else begin
                    wrem_d   = wr_len;
                    wstate_d = W_BODY;
                end
            end else begin
                wrem_d = wrem_q - LEN_WIDTH'(1);
                if (wrem_q == LEN_WIDTH'(1)) begin
                    pkt_done = 1'b1;
                    wstate_d = W_HDR;
                end
            end
        end

        if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (rstate_q == R_HDR) begin
                if (rd_len == '0) begin
                    tail_deq = 1'b1;
                end else begin
                    rrem_d   = rd_len;
                    rstate_d = R_BODY;
                end
            end else begin
                rrem_d = rrem_q - LEN_WIDTH'(1);
                if (rrem_q == LEN_WIDTH'(1)) begin
                    tail_deq = 1'b1;
                    rstate_d = R_HDR;
                end
            end
        end

        case ({wr_en, deq})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase

        case ({pkt_done, tail_deq})
            2'b10:   pkt_cnt_d = pkt_cnt_q + (AW+1)'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - (AW+1)'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        if (bus.valid_in && full && !deq) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            pkt_cnt_q  <= '0;
            wstate_q   <= W_HDR;
            rstate_q   <= R_HDR;
            wrem_q     <= '0;
            rrem_q     <= '0;
            yummy_q    <= 1'b0;
            overflow_q <= 1'b0;
            // Head reads from entry 0 after reset, so clearing it gives data_out=0.
            mem_q[0]   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            pkt_cnt_q  <= pkt_cnt_d;
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            wrem_q     <= wrem_d;
            rrem_q     <= rrem_d;
            yummy_q    <= deq;
            overflow_q <= overflow_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= bus.data_in;
            end
        end
    end
endmodule

// File: tb/tb_noc2_pkt_store_fwd_buf.sv
// tb/tb_noc2_pkt_store_fwd_buf.sv - directed self-checking bench for noc2_pkt_store_fwd_buf
module tb_noc2_pkt_store_fwd_buf;
    localparam int DW        = 64;
    localparam int DEPTH     = 16;
    localparam int LEN_LSB   = 22;
    localparam int LEN_WIDTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  occ;
    logic        ovf;
    int          checks = 0;
    int          failures = 0;
    int          yummy_cnt = 0;
    logic        exp_yummy = 1'b0;
    logic        mon_en = 1'b0;
    logic [DW-1:0] sb[$];

    noc2_pkt_store_fwd_buf_if #(.NOC_DATA_WIDTH(DW)) bus ();

    noc2_pkt_store_fwd_buf #(
        .NOC_DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_LSB(LEN_LSB), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .occupancy_o(occ), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [31:0] tag, input logic [7:0] len);
        logic [DW-1:0] f;
        f = '0;
        f[63:32] = tag;
        f[15:0]  = tag[15:0];
        f[LEN_LSB +: LEN_WIDTH] = len;
        return f;
    endfunction

    // One cycle: drive at posedge+1, return at the following negedge for sampling.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r, input logic push);
        @(posedge clk); #1;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.ready_in = r;
        if (v && push) sb.push_back(d);
        @(negedge clk);
    endtask

    task automatic rst();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && occ != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq(tag, occ, 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard on every handshake plus yummy timing against the previous cycle's handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("yummy_timing", bus.yummy_out, exp_yummy);
            if (bus.yummy_out) yummy_cnt++;
            if (!reset && bus.valid_out && bus.ready_in) begin
                if (sb.size() == 0) check_eq("sb_underflow", 1, 0);
                else check_eq("data_order", bus.data_out, sb.pop_front());
            end
            exp_yummy = !reset && bus.valid_out && bus.ready_in;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] h, first;
        int y0, credits, sent;

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.ready_in = 1'b0;
        rst();
        mon_en = 1'b1;
        check_eq("rst_occ", occ, 0);
        check_eq("rst_valid", bus.valid_out, 0);
        check_eq("rst_yummy", bus.yummy_out, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_data", bus.data_out, 0);

        // Single-flit packet: visible the cycle after the write, one yummy after dequeue.
        h = mk(32'h1111_0001, 8'd0);
        cyc(1'b1, h, 1'b0, 1'b1);
        check_eq("t1_no_bypass", bus.valid_out, 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t1_valid", bus.valid_out, 1);
        check_eq("t1_data", bus.data_out, h);
        check_eq("t1_occ", occ, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t1_yummy", bus.yummy_out, 1);
        check_eq("t1_occ0", occ, 0);
        check_eq("t1_valid0", bus.valid_out, 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t1_yummy_once", bus.yummy_out, 0);

        // L=3 packet written every other cycle, held back until the tail is stored.
        y0 = yummy_cnt;
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) cyc(1'b1, mk(32'h2222_0000 + i, (i == 0) ? 8'd3 : 8'hA5), 1'b1, 1'b1);
            else            cyc(1'b0, '0, 1'b1, 1'b0);
            check_eq("t2_held", bus.valid_out, 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t2_release", bus.valid_out, 1);
        check_eq("t2_occ", occ, 4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            check_eq("t2_stream", bus.valid_out, 1);
            check_eq("t2_yummy", bus.yummy_out, 1);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t2_empty", bus.valid_out, 0);
        check_eq("t2_last_yummy", bus.yummy_out, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t2_yummy_total", yummy_cnt - y0, 4);

        // L=20 packet is longer than the buffer: released by the full term, then R_BODY.
        y0 = yummy_cnt;
        cyc(1'b1, mk(32'h3333_0000, 8'd20), 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) cyc(1'b1, mk(32'h3333_0000 + i, 8'hFF), 1'b0, 1'b1);
        check_eq("t3_gated_15", bus.valid_out, 0);
        cyc(1'b1, mk(32'h3333_0010, 8'h00), 1'b1, 1'b1);
        check_eq("t3_full_valid", bus.valid_out, 1);
        check_eq("t3_full_occ", occ, 16);
        for (int i = 17; i <= 20; i++) begin
            cyc(1'b1, mk(32'h3333_0000 + i, 8'h00), 1'b1, 1'b1);
            check_eq("t3_body_valid", bus.valid_out, 1);
            check_eq("t3_body_occ", occ, 16);
        end
        drain("t3_drain");
        check_eq("t3_yummy_total", yummy_cnt - y0, 21);
        check_eq("t3_ovf", ovf, 0);

        // Back-to-back 2-flit packets: second tail written as the first tail dequeues.
        cyc(1'b1, mk(32'h5A00_0000, 8'd1), 1'b1, 1'b1);
        check_eq("t5_c0", bus.valid_out, 0);
        cyc(1'b1, mk(32'h5A00_0001, 8'd7), 1'b1, 1'b1);
        check_eq("t5_c1", bus.valid_out, 0);
        cyc(1'b1, mk(32'h5B00_0000, 8'd1), 1'b1, 1'b1);
        check_eq("t5_c2", bus.valid_out, 1);
        cyc(1'b1, mk(32'h5B00_0001, 8'd9), 1'b1, 1'b1);
        check_eq("t5_c3", bus.valid_out, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t5_c4", bus.valid_out, 1);
        check_eq("t5_pkt_cnt", dut.pkt_cnt_q, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t5_c5", bus.valid_out, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t5_c6", bus.valid_out, 0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // 40 flits as 2-flit packets under credit flow with a stalling sink.
        y0 = yummy_cnt;
        credits = DEPTH;
        sent = 0;
        for (int c = 0; c < 1000 && (sent < 40 || sb.size() != 0); c++) begin
            logic v;
            v = (sent < 40) && (credits > 0);
            cyc(v, mk(32'h6000_0000 + sent, (sent % 2 == 0) ? 8'd1 : 8'h3C),
                ($urandom_range(0, 3) != 0), 1'b1);
            if (v) begin
                sent++;
                credits--;
            end
            if (bus.yummy_out) credits++;
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("wrap_sent", sent, 40);
        check_eq("wrap_sb_empty", sb.size(), 0);
        check_eq("wrap_yummy_total", yummy_cnt - y0, 40);
        check_eq("wrap_ovf", ovf, 0);

        // Overflow: fill, drop one flit, then write+dequeue while full.
        first = mk(32'h4444_0000, 8'd0);
        cyc(1'b1, first, 1'b0, 1'b1);
        for (int i = 1; i < 16; i++) cyc(1'b1, mk(32'h4444_0000 + i, 8'd0), 1'b0, 1'b1);
        check_eq("t4_occ15", occ, 15);
        cyc(1'b1, mk(32'hDEAD_0000, 8'd5), 1'b0, 1'b0);
        check_eq("t4_full_occ", occ, 16);
        check_eq("t4_ovf_pre", ovf, 0);
        cyc(1'b1, mk(32'h4444_0010, 8'd0), 1'b1, 1'b1);
        check_eq("t4_ovf_set", ovf, 1);
        check_eq("t4_occ_kept", occ, 16);
        check_eq("t4_head_kept", bus.data_out, first);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t4_wd_occ", occ, 16);
        check_eq("t4_ovf_sticky", ovf, 1);
        drain("t4_drain");
        check_eq("t4_ovf_hold", ovf, 1);
        rst();
        check_eq("t4_ovf_cleared", ovf, 0);

        // Reset in the middle of a packet discards it without credit returns.
        y0 = yummy_cnt;
        cyc(1'b1, mk(32'h7777_0000, 8'd5), 1'b1, 1'b1);
        cyc(1'b1, mk(32'h7777_0001, 8'd0), 1'b1, 1'b1);
        cyc(1'b1, mk(32'h7777_0002, 8'd0), 1'b1, 1'b1);
        check_eq("t6_occ_pre", occ, 2);
        check_eq("t6_held", bus.valid_out, 0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t6_occ3", occ, 3);
        rst();
        check_eq("t6_occ0", occ, 0);
        check_eq("t6_valid0", bus.valid_out, 0);
        check_eq("t6_yummy0", bus.yummy_out, 0);
        h = mk(32'h8888_0000, 8'd0);
        cyc(1'b1, h, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_eq("t6_post_valid", bus.valid_out, 1);
        check_eq("t6_post_data", bus.data_out, h);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t6_post_yummy", bus.yummy_out, 1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check_eq("t6_yummy_total", yummy_cnt - y0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
